// File: rtl/res_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port pixel RAM (res_RAM),
// with optional grant locking and a one-cycle registered read return.
module res_ram_arbiter #(
   parameter int AW       = 14,
   parameter int DW       = 8,
   parameter int LOCK_MAX = 16,
   parameter int RR_INIT  = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic          m0_lock,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_ack,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic          m1_lock,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_ack,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          res_rd,
   output logic          res_wr,
   output logic [AW-1:0] res_addr,
   output logic [DW-1:0] res_do,
   input  logic [DW-1:0] res_di
);

   localparam int CW = $clog2(LOCK_MAX + 1);

   logic          last;
   logic          lock_flag;
   logic          rd_src;
   logic [CW-1:0] lock_cnt;

   logic          elig0, elig1;
   logic          owner_req, owner_elig, other_elig, owner_lock;
   logic          lock_act;
   logic          gnt_v, gnt_id;
   logic          g_we, g_lock;
   logic [AW-1:0] g_addr;
   logic [DW-1:0] g_wdata;

   always_comb begin
      elig0      = m0_req & ~m0_ack;
      elig1      = m1_req & ~m1_ack;
      owner_req  = last ? m1_req  : m0_req;
      owner_lock = last ? m1_lock : m0_lock;
      owner_elig = last ? elig1   : elig0;
      other_elig = last ? elig0   : elig1;
      lock_act   = lock_flag & owner_req;

      gnt_v  = 1'b0;
      gnt_id = 1'b0;
      // A live lock blocks the other requester even while the owner sits in its ack cycle.
      if (lock_act) begin
         if ((lock_cnt >= CW'(LOCK_MAX)) && other_elig) begin
            gnt_v  = 1'b1;
            gnt_id = ~last;
         end else if (owner_elig) begin
            gnt_v  = 1'b1;
            gnt_id = last;
         end
      end else if (elig0 && elig1) begin
         gnt_v  = 1'b1;
         gnt_id = ~last;
      end else if (elig0) begin
         gnt_v  = 1'b1;
         gnt_id = 1'b0;
      end else if (elig1) begin
         gnt_v  = 1'b1;
         gnt_id = 1'b1;
      end

      g_we    = gnt_id ? m1_we    : m0_we;
      g_lock  = gnt_id ? m1_lock  : m0_lock;
      g_addr  = gnt_id ? m1_addr  : m0_addr;
      g_wdata = gnt_id ? m1_wdata : m0_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m0_ack    <= 1'b0;
         m1_ack    <= 1'b0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
         res_rd    <= 1'b0;
         res_wr    <= 1'b0;
         res_addr  <= '0;
         res_do    <= '0;
         last      <= (RR_INIT == 0) ? 1'b1 : 1'b0;
         lock_flag <= 1'b0;
         lock_cnt  <= '0;
         rd_src    <= 1'b0;
      end else begin
         m0_ack    <= gnt_v & ~gnt_id;
         m1_ack    <= gnt_v &  gnt_id;
         res_rd    <= gnt_v & ~g_we;
         res_wr    <= gnt_v &  g_we;
         // res_di was refreshed on the negedge inside the res_rd cycle.
         m0_rvalid <= res_rd & ~rd_src;
         m1_rvalid <= res_rd &  rd_src;
         if (res_rd && !rd_src) m0_rdata <= res_di;
         if (res_rd &&  rd_src) m1_rdata <= res_di;

         if (gnt_v) begin
            res_addr  <= g_addr;
            res_do    <= g_wdata;
            last      <= gnt_id;
            lock_flag <= g_lock;
            rd_src    <= gnt_id;
            if (!g_lock)
               lock_cnt <= '0;
            else if (gnt_id != last)
               lock_cnt <= CW'(1);
            else if (lock_cnt < CW'(LOCK_MAX))
               lock_cnt <= lock_cnt + 1'b1;
         end else if (lock_flag && !owner_lock) begin
            lock_flag <= 1'b0;
            lock_cnt  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_res_ram_arbiter.sv
// Scoreboard bench for res_ram_arbiter: directed traffic with hand-computed
// grant order and read data, checked by an independent negedge monitor.
module tb_res_ram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
   logic [13:0] m0_addr, m1_addr, res_addr;
   logic [7:0]  m0_wdata, m1_wdata, m0_rdata, m1_rdata, res_do;
   logic [7:0]  res_di = '0;
   logic        m0_ack, m1_ack, m0_rvalid, m1_rvalid, res_rd, res_wr;

   int n_tests = 0;
   int n_fail  = 0;
   int rv0_cnt = 0;
   int rv1_cnt = 0;

   int         exp_ack[$];
   logic [7:0] exp_rd0[$];
   logic [7:0] exp_rd1[$];

   logic [7:0] mem [0:16383];

   always #5 clk = ~clk;

   res_ram_arbiter #(.AW(14), .DW(8), .LOCK_MAX(16), .RR_INIT(0)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do),
      .res_di(res_di)
   );

   // res_RAM model: write at the posedge closing the strobe, read data on negedge.
   always @(posedge clk) if (res_wr) mem[res_addr] <= res_do;
   always @(negedge clk) if (res_rd) res_di <= mem[res_addr];

   function automatic logic [7:0] fill(input int a);
      return 8'(a ^ (a >> 6));
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected rvalid timing: a read acked in one cycle returns in the next, unless reset intervenes.
   logic erv0 = 1'b0, erv1 = 1'b0, rst_d = 1'b0;
   always @(posedge clk) begin
      rst_d <= reset;
      erv0  <= !reset && m0_ack && res_rd;
      erv1  <= !reset && m1_ack && res_rd;
   end

   logic [7:0] h0 = '0, h1 = '0;
   always @(negedge clk) begin
      if (m0_ack || m1_ack) begin
         n_tests++;
         if (m0_ack && m1_ack) begin
            n_fail++; $display("FAIL ack_mutex: both acks high at %0t", $time);
         end else if (exp_ack.size() == 0) begin
            n_fail++; $display("FAIL ack_unexpected: ack from m%0d with none expected at %0t", m1_ack ? 1 : 0, $time);
         end else begin
            int e;
            e = exp_ack.pop_front();
            if (e != (m1_ack ? 1 : 0)) begin
               n_fail++; $display("FAIL ack_order: got m%0d expected m%0d at %0t", m1_ack ? 1 : 0, e, $time);
            end
         end
      end
      if (res_rd || res_wr) begin
         n_tests++;
         if (res_rd && res_wr) begin
            n_fail++; $display("FAIL strobe_mutex: res_rd=1 res_wr=1 at %0t", $time);
         end
      end
      if (m0_rvalid || erv0) begin
         n_tests++;
         if (m0_rvalid != erv0) begin
            n_fail++; $display("FAIL rv0_timing: got %0b expected %0b at %0t", m0_rvalid, erv0, $time);
         end
      end
      if (m1_rvalid || erv1) begin
         n_tests++;
         if (m1_rvalid != erv1) begin
            n_fail++; $display("FAIL rv1_timing: got %0b expected %0b at %0t", m1_rvalid, erv1, $time);
         end
      end
      if (rst_d) begin h0 = '0; h1 = '0; end
      if (m0_rvalid) begin
         rv0_cnt++;
         n_tests++;
         if (exp_rd0.size() == 0) begin
            n_fail++; $display("FAIL rd0_unexpected: rdata 0x%0h with none expected at %0t", m0_rdata, $time);
         end else begin
            logic [7:0] e;
            e = exp_rd0.pop_front();
            if (m0_rdata != e) begin
               n_fail++; $display("FAIL rd0_data: got 0x%0h expected 0x%0h at %0t", m0_rdata, e, $time);
            end
         end
         h0 = m0_rdata;
      end else begin
         n_tests++;
         if (m0_rdata != h0) begin
            n_fail++; $display("FAIL rd0_hold: got 0x%0h expected 0x%0h at %0t", m0_rdata, h0, $time);
         end
      end
      if (m1_rvalid) begin
         rv1_cnt++;
         n_tests++;
         if (exp_rd1.size() == 0) begin
            n_fail++; $display("FAIL rd1_unexpected: rdata 0x%0h with none expected at %0t", m1_rdata, $time);
         end else begin
            logic [7:0] e;
            e = exp_rd1.pop_front();
            if (m1_rdata != e) begin
               n_fail++; $display("FAIL rd1_data: got 0x%0h expected 0x%0h at %0t", m1_rdata, e, $time);
            end
         end
         h1 = m1_rdata;
      end else begin
         n_tests++;
         if (m1_rdata != h1) begin
            n_fail++; $display("FAIL rd1_hold: got 0x%0h expected 0x%0h at %0t", m1_rdata, h1, $time);
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_req(input int k, input logic r, input logic we, input logic lk,
                          input logic [13:0] a, input logic [7:0] d);
      if (k == 0) begin
         m0_req = r; m0_we = we; m0_lock = lk; m0_addr = a; m0_wdata = d;
      end else begin
         m1_req = r; m1_we = we; m1_lock = lk; m1_addr = a; m1_wdata = d;
      end
   endtask

   // Holds the request until its ack is seen, then releases it just after the ack cycle ends.
   task automatic drive(input int k, input logic we, input logic lk,
                        input logic [13:0] a, input logic [7:0] d);
      int  n;
      logic got;
      n = 0;
      got = 1'b0;
      set_req(k, 1'b1, we, lk, a, d);
      while (!got && n < 100) begin
         @(negedge clk);
         n++;
         got = (k == 0) ? m0_ack : m1_ack;
      end
      if (!got) begin
         n_tests++; n_fail++;
         $display("FAIL ack_timeout: m%0d got no ack within %0d cycles expected ack", k, n);
      end
      tick();
      set_req(k, 1'b0, 1'b0, 1'b0, a, d);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
   endtask

   initial begin
      int s0, s1;
      reset = 1'b1;
      set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
      do_reset();

      @(negedge clk);
      chk("rst_res_rd",  int'(res_rd),   0);
      chk("rst_res_wr",  int'(res_wr),   0);
      chk("rst_res_addr",int'(res_addr), 0);
      chk("rst_res_do",  int'(res_do),   0);
      chk("rst_acks",    int'({m0_ack, m1_ack}), 0);
      chk("rst_rvalids", int'({m0_rvalid, m1_rvalid}), 0);
      chk("rst_rdata",   int'({m0_rdata, m1_rdata}), 0);
      tick();

      // Single write
      exp_ack.push_back(0);
      drive(0, 1'b1, 1'b0, 14'h0005, 8'h3A);
      tick();
      chk("single_write_mem", int'(mem[5]), 8'h3A);

      // Write then read at the top address
      exp_ack.push_back(0);
      exp_ack.push_back(1);
      exp_rd1.push_back(8'h7F);
      drive(0, 1'b1, 1'b0, 14'h3FFF, 8'h7F);
      drive(1, 1'b0, 1'b0, 14'h3FFF, 8'h00);
      repeat (3) tick();

      // Contention after reset: m0 writes, m1 reads each address one cycle later
      do_reset();
      for (int i = 0; i < 8; i++) exp_ack.push_back(i % 2);
      for (int i = 0; i < 4; i++) exp_rd1.push_back(8'hA0 + 8'(i));
      fork
         for (int i = 0; i < 4; i++) drive(0, 1'b1, 1'b0, 14'h0010 + 14'(i), 8'hA0 + 8'(i));
         for (int i = 0; i < 4; i++) drive(1, 1'b0, 1'b0, 14'h0010 + 14'(i), 8'h00);
         begin
            int n, c;
            n = 0;
            while (!(res_rd || res_wr) && n < 20) begin @(negedge clk); n++; end
            c = (res_rd || res_wr) ? 1 : 0;
            for (int j = 0; j < 7; j++) begin
               @(negedge clk);
               if (res_rd || res_wr) c++;
            end
            chk("contention_busy_cycles", c, 8);
         end
      join
      repeat (3) tick();

      // Lock override: 16 locked m0 grants, then m1, then m0 again
      do_reset();
      for (int i = 0; i < 16; i++) exp_ack.push_back(0);
      exp_ack.push_back(1);
      exp_ack.push_back(0);
      for (int i = 0; i < 17; i++) exp_rd0.push_back(8'hA0);
      exp_rd1.push_back(8'h7F);
      fork
         for (int i = 0; i < 17; i++) drive(0, 1'b0, 1'b1, 14'h0010, 8'h00);
         drive(1, 1'b0, 1'b0, 14'h3FFF, 8'h00);
      join
      repeat (3) tick();

      // Reset asserted during the ack cycle of an m1 read
      begin
         int n;
         n = 0;
         exp_ack.push_back(1);
         set_req(1, 1'b1, 1'b0, 1'b0, 14'h3FFF, 8'h00);
         do begin @(negedge clk); n++; end while (!m1_ack && n < 20);
         chk("rst_mid_ack_seen", int'(m1_ack), 1);
         reset = 1'b1;
         set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
         @(negedge clk);
         chk("rst_mid_outputs", int'({m0_ack, m1_ack, m0_rvalid, m1_rvalid, res_rd, res_wr}), 0);
         chk("rst_mid_addr",  int'(res_addr), 0);
         chk("rst_mid_rdata", int'(m1_rdata), 0);
         tick();
         reset = 1'b0;
         repeat (4) tick();
         chk("rst_mid_mem", int'(mem[14'h3FFF]), 8'h7F);
      end

      // Full sweep: alternating fill then alternating read of every address
      for (int i = 0; i < 16384; i++) exp_ack.push_back(i % 2);
      fork
         for (int i = 0; i < 8192; i++) drive(0, 1'b1, 1'b0, 14'(2*i),   fill(2*i));
         for (int i = 0; i < 8192; i++) drive(1, 1'b1, 1'b0, 14'(2*i+1), fill(2*i+1));
      join
      tick();
      s0 = rv0_cnt;
      s1 = rv1_cnt;
      for (int i = 0; i < 16384; i++) exp_ack.push_back(i % 2);
      for (int i = 0; i < 8192; i++) begin
         exp_rd0.push_back(fill(2*i));
         exp_rd1.push_back(fill(2*i+1));
      end
      fork
         for (int i = 0; i < 8192; i++) drive(0, 1'b0, 1'b0, 14'(2*i),   8'h00);
         for (int i = 0; i < 8192; i++) drive(1, 1'b0, 1'b0, 14'(2*i+1), 8'h00);
      join
      repeat (4) tick();
      chk("sweep_rv0_count", rv0_cnt - s0, 8192);
      chk("sweep_rv1_count", rv1_cnt - s1, 8192);

      chk("left_exp_ack", exp_ack.size(), 0);
      chk("left_exp_rd0", exp_rd0.size(), 0);
      chk("left_exp_rd1", exp_rd1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
